pll_reconfig_ctrl: RTL

- Sequencer for dynamic reconfiguration of the ms72xx PLL.
- Holds shadow divider/duty/phase registers written by a host-side register port.
- On an apply request it validates the shadow set, commits it to the PLL dyn_* inputs, and pulses pll_rst.
- It then waits for a stable lock, retrying on timeout, and reports done or error. Sits between the system config bus and the PLL instance.

---
 rtl/pll_reconfig_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_ctrl.sv
// Dynamic-reconfiguration sequencer for the ms72xx PLL: shadow registers,
// config validation, commit to dyn_* outputs, reset pulse, lock wait with retry.
module pll_reconfig_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [12:0] wr_data_i,
  input  logic        apply_req_i,
  input  logic        pll_lock_i,
  output logic        pll_rst_o,
  output logic [9:0]  dyn_idiv_o,
  output logic [9:0]  dyn_fdiv_o,
  output logic [49:0] dyn_odiv_o,
  output logic [49:0] dyn_duty_o,
  output logic [64:0] dyn_phase_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [1:0]  err_code_o,
  output logic        locked_o,
  output logic        lock_lost_o
);

  localparam int unsigned MaxA     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxB     = (LOCK_STABLE > MAX_RETRY) ? LOCK_STABLE : MAX_RETRY;
  localparam int unsigned MaxParam = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW     = $clog2(MaxParam) + 1;

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] RetryLast   = CntW'(MAX_RETRY - 1);

  localparam logic [9:0]  DefIdiv  = 10'd2;
  localparam logic [9:0]  DefFdiv  = 10'd32;
  localparam logic [9:0]  DefOdiv  = 10'd100;
  localparam logic [9:0]  DefDuty  = 10'd100;
  localparam logic [12:0] DefPhase = 13'd16;

  typedef enum logic [2:0] {
    StIdle, StCheck, StReset, StWaitLock, StStable, StDone, StFail
  } state_e;

  state_e state_q;

  logic [1:0]       sync_q;
  logic             lock_s;
  logic [9:0]       sh_idiv_q, sh_fdiv_q;
  logic [4:0][9:0]  sh_odiv_q, sh_duty_q;
  logic [4:0][12:0] sh_phase_q;
  logic [9:0]       dyn_idiv_q, dyn_fdiv_q;
  logic [4:0][9:0]  dyn_odiv_q, dyn_duty_q;
  logic [4:0][12:0] dyn_phase_q;
  logic [CntW-1:0]  cnt_q, retry_cnt_q;
  logic             pll_rst_q, busy_q, done_q, err_q, locked_q, lock_lost_q;
  logic [1:0]       err_code_q;
  logic             cfg_ok;

  assign lock_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], pll_lock_i};
  end

  // Shadow register file; writes land in any state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_idiv_q  <= DefIdiv;
      sh_fdiv_q  <= DefFdiv;
      sh_odiv_q  <= {5{DefOdiv}};
      sh_duty_q  <= {5{DefDuty}};
      sh_phase_q <= {5{DefPhase}};
    end else if (wr_en_i) begin
      if (wr_addr_i == 5'd0) sh_idiv_q <= wr_data_i[9:0];
      if (wr_addr_i == 5'd1) sh_fdiv_q <= wr_data_i[9:0];
      for (int i = 0; i < 5; i++) begin
        if (wr_addr_i == 5'(2 + i))  sh_odiv_q[i]  <= wr_data_i[9:0];
        if (wr_addr_i == 5'(7 + i))  sh_duty_q[i]  <= wr_data_i[9:0];
        if (wr_addr_i == 5'(12 + i)) sh_phase_q[i] <= wr_data_i;
      end
    end
  end

  // Shadow set is valid when no divider/duty is zero and every duty < 2*odiv.
  always_comb begin
    cfg_ok = (sh_idiv_q != '0) && (sh_fdiv_q != '0);
    for (int i = 0; i < 5; i++) begin
      if ((sh_odiv_q[i] == '0) || (sh_duty_q[i] == '0) ||
          ({1'b0, sh_duty_q[i]} >= {sh_odiv_q[i], 1'b0})) begin
        cfg_ok = 1'b0;
      end
    end
  end

  // Sequencer FSM with registered outputs; cnt_q is shared by RESET, WAIT_LOCK and STABLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      retry_cnt_q <= '0;
      pll_rst_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
      dyn_idiv_q  <= DefIdiv;
      dyn_fdiv_q  <= DefFdiv;
      dyn_odiv_q  <= {5{DefOdiv}};
      dyn_duty_q  <= {5{DefDuty}};
      dyn_phase_q <= {5{DefPhase}};
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (apply_req_i) begin
            state_q     <= StCheck;
            busy_q      <= 1'b1;
            retry_cnt_q <= '0;
            err_code_q  <= 2'd0;
            lock_lost_q <= 1'b0;
            locked_q    <= 1'b0;
          end else if (locked_q && !lock_s) begin
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b1;
          end
        end
        StCheck: begin
          if (!cfg_ok) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd1;
            busy_q     <= 1'b0;
            state_q    <= StIdle;
          end else begin
            dyn_idiv_q  <= sh_idiv_q;
            dyn_fdiv_q  <= sh_fdiv_q;
            dyn_odiv_q  <= sh_odiv_q;
            dyn_duty_q  <= sh_duty_q;
            dyn_phase_q <= sh_phase_q;
            pll_rst_q   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StReset;
          end
        end
        StReset: begin
          if (cnt_q == RstLast) begin
            pll_rst_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StWaitLock;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            // The lock_s cycle seen here is the first of the stable run.
            if (LOCK_STABLE <= 1) begin
              done_q   <= 1'b1;
              locked_q <= 1'b1;
              state_q  <= StDone;
            end else begin
              cnt_q   <= CntW'(1);
              state_q <= StStable;
            end
          end else if (cnt_q == TimeoutLast) begin
            if (retry_cnt_q < RetryLast) begin
              retry_cnt_q <= retry_cnt_q + 1'b1;
              pll_rst_q   <= 1'b1;
              cnt_q       <= '0;
              state_q     <= StReset;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
              state_q    <= StFail;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStable: begin
          // A dropout restarts the lock wait without consuming a retry.
          if (!lock_s) begin
            cnt_q   <= '0;
            state_q <= StWaitLock;
          end else if (cnt_q == StableLast) begin
            done_q   <= 1'b1;
            locked_q <= 1'b1;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StFail: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign dyn_idiv_o  = dyn_idiv_q;
  assign dyn_fdiv_o  = dyn_fdiv_q;
  assign dyn_odiv_o  = dyn_odiv_q;
  assign dyn_duty_o  = dyn_duty_q;
  assign dyn_phase_o = dyn_phase_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;
  assign locked_o    = locked_q;
  assign lock_lost_o = lock_lost_q;

endmodule
